// File: rtl/vga_timing_if.sv
// Raster timing bundle: sync strobes, coordinates and pixel/frame strobes.
interface vga_timing_if #(parameter int CW = 10);
  logic          hsync;
  logic          vsync;
  logic          visible;
  logic [CW-1:0] px_x;
  logic [CW-1:0] px_y;
  logic          pixel_tick;
  logic          frame_end;

  modport master (output hsync, vsync, visible, px_x, px_y, pixel_tick, frame_end);
  modport slave  (input  hsync, vsync, visible, px_x, px_y, pixel_tick, frame_end);
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 raster generator at half the system clock: each pixel spans two
// clocks; sync/visible are registered from next-state counters so they never skew.
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CW        = 10
) (
  input logic          clock,
  input logic          reset,
  vga_timing_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_LO  = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_HI  = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_LO  = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_HI  = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic          armed;
  logic          phase;
  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          hsync, vsync, visible, frame_end;

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (phase) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
      end else begin
        h_nxt = h_cnt + CW'(1);
      end
    end
  end

  // The first edge after release only loads the decode of (0,0) and leaves
  // phase at 0, so pixel (0,0) lasts two clocks like every other pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed     <= 1'b0;
      phase     <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      visible   <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      armed     <= 1'b1;
      phase     <= armed ? ~phase : 1'b0;
      h_cnt     <= h_nxt;
      v_cnt     <= v_nxt;
      visible   <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      hsync     <= !((h_nxt >= HS_LO) && (h_nxt < HS_HI));
      vsync     <= !((v_nxt >= VS_LO) && (v_nxt < VS_HI));
      // Next cycle is the tick cycle of the last pixel of the frame.
      frame_end <= armed && !phase && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end
  end

  assign vga.hsync      = hsync;
  assign vga.vsync      = vsync;
  assign vga.visible    = visible;
  assign vga.px_x       = h_cnt;
  assign vga.px_y       = v_cnt;
  assign vga.pixel_tick = phase;
  assign vga.frame_end  = frame_end;
endmodule
